sd_sweep_ctrl: RTL and testbench
================================

// Module: sd_sweep_ctrl
// PURPOSE
//  Sequencer for the two-piece sigma-delta tone generator. Accepts a sweep config over a
//  valid/ready port, holds the modulator in reset while settling, then steps the frequency
//  word kin from start to stop in fixed increments, dwelling a programmable number of cycles
//  per step. Sits between the host/config logic and the modulator's kin/reset inputs.
// PARAMETERS
//  BITWIDTH    40  modulator accumulator width; kin width KW = BITWIDTH-12 (localparam)
//  DWELL_W     16  width of the dwell count
//  SETTLE_CYC  4   cycles mod_reset stays high with kin=start before RUN (>=1)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        async, active-high
//  cfg_valid   in   1        config beat present
//  cfg_ready   out  1        config can be accepted
//  cfg_start   in   KW       first frequency word
//  cfg_stop    in   KW       last frequency word (inclusive bound)
//  cfg_step    in   KW       increment per dwell; 0 = fixed tone
//  cfg_dwell   in   DWELL_W  step held for cfg_dwell+1 cycles
//  cfg_err     out  1        1-cycle pulse: config rejected
//  run         in   1        level; 1 = sweep, 0 = stop/abort
//  mod_reset   out  1        drives modulator reset
//  kin         out  KW       drives modulator kin
//  busy        out  1        1 in SETTLE or RUN
//  sweep_done  out  1        1-cycle pulse at each sweep end
// BEHAVIOUR
//  - All outputs registered. Reset (async): state=IDLE, cfg_ready=1, mod_reset=1, kin=0,
//    busy=0, sweep_done=0, cfg_err=0, config regs cleared.
//  - States: IDLE (no valid config), ARMED (config held), SETTLE, RUN.
//  - cfg_ready=1 in IDLE and ARMED only. Handshake = cfg_valid & cfg_ready, captured on clk.
//    Accept with cfg_start>cfg_stop: cfg_err pulses next cycle, config regs and state unchanged.
//    Legal accept: latch all four fields; IDLE->ARMED; in ARMED new config replaces old.
//  - ARMED & run=1 -> SETTLE: kin=cfg_start, mod_reset=1, busy=1, hold SETTLE_CYC cycles.
//  - SETTLE done -> RUN: mod_reset=0 in the first RUN cycle. Dwell counter counts
//    cfg_dwell+1 cycles per kin value (dwell=0: kin changes every cycle).
//  - Step at dwell end: next = kin + cfg_step computed in KW+1 bits (no wrap). If next>cfg_stop:
//    kin<=cfg_start, sweep_done=1 for that cycle, dwell restarts; else kin<=next.
//    cfg_step=0: kin stays cfg_start forever, sweep_done never pulses.
//    cfg_start==cfg_stop with step>0: sweep_done every dwell period.
//  - run=0 in SETTLE/RUN: next cycle ARMED, mod_reset=1, kin=0, busy=0, dwell cleared;
//    config retained; no sweep_done. run=0 and a dwell end in same cycle: abort wins.
//  - run=1 in IDLE is ignored. run held high in ARMED after abort restarts from SETTLE.
//  - Reset mid-sweep: immediate return to reset values; config lost.
// CONFIGURATION
//  SD_SWEEP_TRIANGLE_EN undefined: sawtooth sweep as above (wrap to cfg_start).
//  SD_SWEEP_TRIANGLE_EN defined: direction register (reset=up). At up end, if kin+step>stop,
//    direction<=down, kin<=kin-step (clamped to cfg_start), sweep_done pulses; going down,
//    if kin-step<cfg_start (KW+1-bit signed compare), direction<=up, kin<=kin+step (clamped
//    to cfg_stop), sweep_done pulses. Entering SETTLE forces direction=up. step=0: constant.
// TESTING
//  1 Reset: assert reset mid-RUN -> same-cycle mod_reset=1, kin=0, cfg_ready=1, busy=0.
//  2 cfg start=100,stop=130,step=10,dwell=2, run=1 -> 4 cycles mod_reset=1 kin=100, then kin
//    100,110,120,130 each 3 cycles, then 100 with sweep_done pulse; repeats.
//  3 cfg start=200,stop=100 -> cfg_err pulse, state stays IDLE, run=1 gives no busy.
//  4 run dropped in 2nd dwell cycle of kin=110 -> next cycle ARMED, kin=0, mod_reset=1;
//    run re-raised -> SETTLE restarts at kin=100.
//  5 start=stop=2^KW-1, step=5, dwell=0 -> no overflow; kin constant, sweep_done every cycle.
//  6 SD_SWEEP_TRIANGLE_EN, start=0,stop=30,step=10,dwell=0 -> kin 0,10,20,30,20,10,0,10...,
//    sweep_done on the cycles kin turns at 30 and at 0.

Source files
------------

// File: rtl/sd_sweep_ctrl.sv
// Frequency-sweep sequencer for the two-piece sigma-delta tone generator: takes a sweep
// config, settles the modulator in reset, then steps kin. Define SD_SWEEP_TRIANGLE_EN for up/down sweeps.
module sd_sweep_ctrl #(
  parameter  int BITWIDTH   = 40,
  parameter  int DWELL_W    = 16,
  parameter  int SETTLE_CYC = 4,
  localparam int KW         = BITWIDTH - 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [KW-1:0]      cfg_start,
  input  logic [KW-1:0]      cfg_stop,
  input  logic [KW-1:0]      cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               cfg_err,
  input  logic               run,
  output logic               mod_reset,
  output logic [KW-1:0]      kin,
  output logic               busy,
  output logic               sweep_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  logic [1:0]         state_q, state_d;
  logic [KW-1:0]      cfg_start_q, cfg_start_d;
  logic [KW-1:0]      cfg_stop_q, cfg_stop_d;
  logic [KW-1:0]      cfg_step_q, cfg_step_d;
  logic [DWELL_W-1:0] cfg_dwell_q, cfg_dwell_d;
  logic [KW-1:0]      kin_q, kin_d;
  logic               mod_reset_q, mod_reset_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               cfg_err_q, cfg_err_d;
  logic               sweep_done_q, sweep_done_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic               cfg_accept;
  logic               cfg_bad;
  logic               cfg_ok;
  logic               sweeping;
  logic [KW:0]        kin_sum;
  logic               sum_over;

  // One extra bit keeps kin+step from wrapping near the top of the kin range.
  assign cfg_accept = cfg_valid & cfg_ready_q;
  assign cfg_bad    = cfg_start > cfg_stop;
  assign cfg_ok     = cfg_accept & ~cfg_bad;
  assign sweeping   = (state_q == ST_SETTLE) || (state_q == ST_RUN);
  assign kin_sum    = {1'b0, kin_q} + {1'b0, cfg_step_q};
  assign sum_over   = kin_sum > {1'b0, cfg_stop_q};

`ifdef SD_SWEEP_TRIANGLE_EN
  logic               dir_down_q, dir_down_d;
  logic signed [KW:0] kin_diff;
  logic               diff_under;

  assign kin_diff   = $signed({1'b0, kin_q}) - $signed({1'b0, cfg_step_q});
  assign diff_under = kin_diff < $signed({1'b0, cfg_start_q});
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    state_d      = state_q;
    cfg_start_d  = cfg_start_q;
    cfg_stop_d   = cfg_stop_q;
    cfg_step_d   = cfg_step_q;
    cfg_dwell_d  = cfg_dwell_q;
    kin_d        = kin_q;
    mod_reset_d  = mod_reset_q;
    busy_d       = busy_q;
    cfg_ready_d  = cfg_ready_q;
    cfg_err_d    = 1'b0;
    sweep_done_d = 1'b0;
    settle_cnt_d = settle_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
`ifdef SD_SWEEP_TRIANGLE_EN
    dir_down_d   = dir_down_q;
`endif

    if (cfg_accept) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        cfg_start_d = cfg_start;
        cfg_stop_d  = cfg_stop;
        cfg_step_d  = cfg_step;
        cfg_dwell_d = cfg_dwell;
        if (state_q == ST_IDLE) state_d = ST_ARMED;
      end
    end

    if (sweeping && !run) begin
      // Abort takes priority over any settle or dwell event this cycle.
      state_d      = ST_ARMED;
      mod_reset_d  = 1'b1;
      kin_d        = '0;
      busy_d       = 1'b0;
      cfg_ready_d  = 1'b1;
      settle_cnt_d = '0;
      dwell_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (run) begin
            state_d      = ST_SETTLE;
            kin_d        = cfg_ok ? cfg_start : cfg_start_q;
            mod_reset_d  = 1'b1;
            busy_d       = 1'b1;
            cfg_ready_d  = 1'b0;
            settle_cnt_d = SETTLE_LOAD;
            dwell_cnt_d  = '0;
`ifdef SD_SWEEP_TRIANGLE_EN
            dir_down_d   = 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d     = ST_RUN;
            mod_reset_d = 1'b0;
            dwell_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q - SW'(1);
          end
        end
        ST_RUN: begin
          if (dwell_cnt_q == cfg_dwell_q) begin
            dwell_cnt_d = '0;
`ifdef SD_SWEEP_TRIANGLE_EN
            if (!dir_down_q) begin
              if (sum_over) begin
                dir_down_d   = 1'b1;
                sweep_done_d = 1'b1;
                kin_d        = diff_under ? cfg_start_q : kin_diff[KW-1:0];
              end else begin
                kin_d = kin_sum[KW-1:0];
              end
            end else begin
              if (diff_under) begin
                dir_down_d   = 1'b0;
                sweep_done_d = 1'b1;
                kin_d        = sum_over ? cfg_stop_q : kin_sum[KW-1:0];
              end else begin
                kin_d = kin_diff[KW-1:0];
              end
            end
`else
            // A zero step never exceeds stop, so a fixed tone simply holds cfg_start.
            if (sum_over) begin
              kin_d        = cfg_start_q;
              sweep_done_d = 1'b1;
            end else begin
              kin_d = kin_sum[KW-1:0];
            end
`endif
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cfg_start_q  <= '0;
      cfg_stop_q   <= '0;
      cfg_step_q   <= '0;
      cfg_dwell_q  <= '0;
      kin_q        <= '0;
      mod_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      settle_cnt_q <= '0;
      dwell_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      cfg_start_q  <= cfg_start_d;
      cfg_stop_q   <= cfg_stop_d;
      cfg_step_q   <= cfg_step_d;
      cfg_dwell_q  <= cfg_dwell_d;
      kin_q        <= kin_d;
      mod_reset_q  <= mod_reset_d;
      busy_q       <= busy_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      sweep_done_q <= sweep_done_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

`ifdef SD_SWEEP_TRIANGLE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dir_down_q <= 1'b0;
    else       dir_down_q <= dir_down_d;
  end
`endif

  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign mod_reset  = mod_reset_q;
  assign kin        = kin_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_sd_sweep_ctrl.sv
// Self-checking bench for sd_sweep_ctrl: directed scenarios plus random configs/run toggling,
// checked every cycle against a model that derives outputs from elapsed time and a precomputed sweep list.
module tb_sd_sweep_ctrl;
  localparam int BITWIDTH   = 40;
  localparam int KW         = BITWIDTH - 12;
  localparam int DWELL_W    = 16;
  localparam int SETTLE_CYC = 4;
  localparam int SEQ_N      = 512;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [KW-1:0]      cfg_start, cfg_stop, cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_err;
  logic               run;
  logic               mod_reset;
  logic [KW-1:0]      kin;
  logic               busy;
  logic               sweep_done;

  always #5 clk = ~clk;

  sd_sweep_ctrl #(
    .BITWIDTH(BITWIDTH), .DWELL_W(DWELL_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
    .cfg_err(cfg_err), .run(run),
    .mod_reset(mod_reset), .kin(kin), .busy(busy), .sweep_done(sweep_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: whether a config is held, whether a sweep is active, and how long it has run.
  bit     m_has_cfg, m_active, m_err;
  longint m_start, m_stop, m_step, m_dwell, m_t;
  longint seq_kin [SEQ_N];
  bit     seq_done [SEQ_N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kin value for each dwell period of a sweep, and whether that period begins a new sweep.
  function automatic void gen_seq();
    longint k;
`ifdef SD_SWEEP_TRIANGLE_EN
    bit down = 1'b0;
`endif
    seq_kin[0]  = m_start;
    seq_done[0] = 1'b0;
    for (int p = 1; p < SEQ_N; p++) begin
      k = seq_kin[p-1];
      seq_done[p] = 1'b0;
`ifdef SD_SWEEP_TRIANGLE_EN
      if (!down) begin
        if (k + m_step > m_stop) begin
          down = 1'b1; seq_done[p] = 1'b1;
          k = (k - m_step < m_start) ? m_start : k - m_step;
        end else k = k + m_step;
      end else begin
        if (k - m_step < m_start) begin
          down = 1'b0; seq_done[p] = 1'b1;
          k = (k + m_step > m_stop) ? m_stop : k + m_step;
        end else k = k - m_step;
      end
`else
      if (k + m_step > m_stop) begin
        k = m_start; seq_done[p] = 1'b1;
      end else k = k + m_step;
`endif
      seq_kin[p] = k;
    end
  endfunction

  function automatic void model_reset();
    m_has_cfg = 0; m_active = 0; m_err = 0;
    m_start = 0; m_stop = 0; m_step = 0; m_dwell = 0; m_t = 0;
  endfunction

  function automatic void model_edge();
    bit rdy = !m_active;
    bit had = m_has_cfg;
    bit acc = cfg_valid && rdy;
    bit bad = longint'(cfg_start) > longint'(cfg_stop);
    m_err = acc && bad;
    if (acc && !bad) begin
      m_start = cfg_start; m_stop = cfg_stop; m_step = cfg_step; m_dwell = cfg_dwell;
      m_has_cfg = 1;
      gen_seq();
    end
    if (m_active) begin
      if (!run) m_active = 0;
      else m_t++;
    end else if (had && run) begin
      m_active = 1; m_t = 0;
    end
  endfunction

  task automatic compare(input string tag);
    longint ekin, r, p, ph;
    bit erdy, emr, ebusy, edone;
    if (!m_active) begin
      erdy = 1; emr = 1; ekin = 0; ebusy = 0; edone = 0;
    end else begin
      erdy = 0; ebusy = 1;
      if (m_t < SETTLE_CYC) begin
        emr = 1; ekin = m_start; edone = 0;
      end else begin
        r  = m_t - SETTLE_CYC;
        p  = r / (m_dwell + 1);
        ph = r % (m_dwell + 1);
        if (p >= SEQ_N) p = SEQ_N - 1;
        emr   = 0;
        ekin  = seq_kin[int'(p)];
        edone = (ph == 0) && seq_done[int'(p)];
      end
    end
    check({tag, ".cfg_ready"},  cfg_ready,  erdy);
    check({tag, ".mod_reset"},  mod_reset,  emr);
    check({tag, ".kin"},        kin,        ekin);
    check({tag, ".busy"},       busy,       ebusy);
    check({tag, ".sweep_done"}, sweep_done, edone);
    check({tag, ".cfg_err"},    cfg_err,    m_err);
  endtask

  task automatic tick(input string tag);
    if (reset) model_reset();
    else       model_edge();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic send_cfg(input string tag, input logic [KW-1:0] s, input logic [KW-1:0] e,
                          input logic [KW-1:0] st, input logic [DWELL_W-1:0] d);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = d;
    cfg_valid = 1'b1;
    tick(tag);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int exp_kin [18] = '{100, 100, 100, 100, 100, 100, 100, 110, 110,
                         110, 120, 120, 120, 130, 130, 130, 100, 100};
    logic [KW-1:0] kmax;
    kmax = '1;

    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
    model_reset();
    #1;
    compare("por");
    tick("por_hold");
    tick("por_hold");
    reset = 1'b0;
    tick("idle");

    // Basic sawtooth sweep with explicit expected kin trace.
    send_cfg("t2_cfg", 100, 130, 10, 2);
    check("t2.ready_armed", cfg_ready, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick("t2");
      check("t2.kin_trace", kin, exp_kin[i]);
      check("t2.done_trace", sweep_done, (i == 16));
      check("t2.mrst_trace", mod_reset, (i < 4));
    end
    repeat (14) tick("t2_repeat");

    // Asynchronous reset in the middle of a running sweep.
    reset = 1'b1;
    #1;
    model_reset();
    compare("t1");
    check("t1.kin_now", kin, 0);
    check("t1.mrst_now", mod_reset, 1'b1);
    check("t1.ready_now", cfg_ready, 1'b1);
    check("t1.busy_now", busy, 1'b0);
    tick("t1_hold");
    reset = 1'b0;
    run = 1'b0;
    tick("t1_after");

    // Illegal config from IDLE: error pulse, no arming.
    send_cfg("t3_cfg", 200, 100, 5, 0);
    check("t3.err_pulse", cfg_err, 1'b1);
    tick("t3_err_clear");
    check("t3.err_low", cfg_err, 1'b0);
    run = 1'b1;
    repeat (5) tick("t3_run_ignored");
    check("t3.not_busy", busy, 1'b0);
    run = 1'b0;
    tick("t3_end");

    // Abort during the second dwell cycle of kin=110, then restart.
    send_cfg("t4_cfg", 100, 130, 10, 2);
    run = 1'b1;
    repeat (SETTLE_CYC + 3 + 2) tick("t4_sweep");
    check("t4.kin_before", kin, 110);
    run = 1'b0;
    tick("t4_abort");
    check("t4.kin_abort", kin, 0);
    check("t4.mrst_abort", mod_reset, 1'b1);
    check("t4.busy_abort", busy, 1'b0);
    run = 1'b1;
    tick("t4_restart");
    check("t4.kin_restart", kin, 100);
    check("t4.busy_restart", busy, 1'b1);
    repeat (10) tick("t4_rerun");
    run = 1'b0;
    tick("t4_end");

    // Top of the kin range: no overflow, sweep_done every cycle.
    send_cfg("t5_cfg", kmax, kmax, 5, 0);
    run = 1'b1;
    repeat (SETTLE_CYC + 2) tick("t5_sweep");
    check("t5.kin_top", kin, kmax);
    check("t5.done_each", sweep_done, 1'b1);
    repeat (8) tick("t5_sweep");
    run = 1'b0;
    tick("t5_end");

    // Zero step: fixed tone, never a sweep_done.
    send_cfg("t7_cfg", 50, 60, 0, 1);
    run = 1'b1;
    repeat (20) tick("t7_fixed");
    run = 1'b0;
    tick("t7_end");

`ifdef SD_SWEEP_TRIANGLE_EN
    send_cfg("t6_cfg", 0, 30, 10, 0);
    run = 1'b1;
    repeat (24) tick("t6_tri");
    run = 1'b0;
    tick("t6_end");
`endif

    // Random configs, random run toggling and handshakes in any state.
    for (int seg = 0; seg < 40; seg++) begin
      if (seg % 13 == 12) begin
        reset = 1'b1;
        tick("rnd_reset");
        reset = 1'b0;
      end
      send_cfg("rnd_cfg", KW'($urandom_range(0, 500)), KW'($urandom_range(0, 800)),
               KW'($urandom_range(0, 60)), DWELL_W'($urandom_range(0, 3)));
      run = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) begin
        if ($urandom_range(0, 15) == 0) run = ~run;
        if ($urandom_range(0, 20) == 0) begin
          cfg_start = KW'($urandom_range(0, 500));
          cfg_stop  = KW'($urandom_range(0, 800));
          cfg_step  = KW'($urandom_range(0, 60));
          cfg_dwell = DWELL_W'($urandom_range(0, 3));
          cfg_valid = 1'b1;
        end
        tick("rnd");
        cfg_valid = 1'b0;
      end
      run = 1'b0;
      tick("rnd_stop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
